// File: rtl/mem_copy_engine.sv
// ---------------------------------------------------------------------------
// mem_copy_engine
//
// Bus master for the 16-bit word-addressed data memory. Copies a block of
// `len` words from `src_addr` to `dst_addr` using one READ cycle followed by
// one WRITE cycle per word (2 cycles per word). When the destination lies
// above the source the copy runs top-down, so overlapping forward moves
// never overwrite source words before they have been read.
//
// Optional build macro: MEM_COPY_CHECKSUM_EN
//   defined   -> `checksum` accumulates every written word (mod 2^16);
//                cleared on each accepted start, held after completion.
//   undefined -> `checksum` is tied to 0 and no accumulator exists.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   start               request pulse, accepted only while idle
//   src_addr, dst_addr  first source / destination word address
//   len                 word count (0 = complete immediately, no transfer)
//   busy                high in READ, WRITE and DONE
//   done                one-cycle completion pulse (DONE state)
//   mem_address         memory address (holds its value while idle)
//   mem_read_enable     memory read strobe, READ state only
//   mem_write_enable    memory write strobe, WRITE state only
//   mem_write_data      word being written (holds its value while idle)
//   mem_read_data       memory read data, valid combinationally in READ
//   checksum            running sum of copied words (see macro above)
//
// Handshake: the memory is a zero-wait-state responder. A strobe asserted in
// a cycle is a complete transfer for that cycle; there is no ready/stall.
// start is a single-cycle request with no back-pressure: it is taken only
// in IDLE and dropped silently in every other state.
// ---------------------------------------------------------------------------
module mem_copy_engine #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [15:0]       len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read_enable,
  output logic              mem_write_enable,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [15:0]       checksum
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] sp;
  logic [ADDR_W-1:0] dp;
  logic [15:0]       cnt;
  logic              step_down;
  logic [DATA_W-1:0] data_buf;
  logic [ADDR_W-1:0] addr_q;

  // Start-time pointer computation. The top-down case points at the last
  // word of each block; all arithmetic wraps modulo 2^ADDR_W.
  logic              start_ok;
  logic              start_down;
  logic [ADDR_W-1:0] len_a;
  logic [ADDR_W-1:0] start_sp;
  logic [ADDR_W-1:0] start_dp;

  always_comb begin
    start_ok   = (state == S_IDLE) && start;
    start_down = (dst_addr > src_addr);
    len_a      = ADDR_W'(len);
    start_sp   = src_addr;
    start_dp   = dst_addr;
    if (start_down) begin
      start_sp = src_addr + len_a - ADDR_ONE;
      start_dp = dst_addr + len_a - ADDR_ONE;
    end
  end

  // Pointer advance applied at the end of each WRITE cycle.
  logic [ADDR_W-1:0] sp_next;
  logic [ADDR_W-1:0] dp_next;
  logic              last_word;

  always_comb begin
    sp_next   = step_down ? (sp - ADDR_ONE) : (sp + ADDR_ONE);
    dp_next   = step_down ? (dp - ADDR_ONE) : (dp + ADDR_ONE);
    last_word = (cnt == 16'd1);
  end

  // Main sequencer. addr_q is the registered memory address: it is loaded
  // one edge ahead of the state that uses it, so the mem_* outputs come
  // straight from flops and start never reaches them combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      sp        <= '0;
      dp        <= '0;
      cnt       <= '0;
      step_down <= 1'b0;
      data_buf  <= '0;
      addr_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            cnt       <= len;
            sp        <= start_sp;
            dp        <= start_dp;
            step_down <= start_down;
            if (len == 16'd0) begin
              state <= S_DONE;
            end else begin
              state  <= S_READ;
              addr_q <= start_sp;
            end
          end
        end
        S_READ: begin
          data_buf <= mem_read_data;
          addr_q   <= dp;
          state    <= S_WRITE;
        end
        S_WRITE: begin
          sp  <= sp_next;
          dp  <= dp_next;
          cnt <= cnt - 16'd1;
          if (last_word) begin
            state <= S_DONE;
          end else begin
            addr_q <= sp_next;
            state  <= S_READ;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Output decode from registered state only.
  always_comb begin
    busy             = (state != S_IDLE);
    done             = (state == S_DONE);
    mem_read_enable  = (state == S_READ);
    mem_write_enable = (state == S_WRITE);
    mem_address      = addr_q;
    mem_write_data   = data_buf;
  end

`ifdef MEM_COPY_CHECKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
    end else if (start_ok) begin
      sum_q <= '0;
    end else if (state == S_WRITE) begin
      sum_q <= sum_q + 16'(data_buf);
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// ---------------------------------------------------------------------------
// tb_mem_copy_engine
//
// Bench for mem_copy_engine with a behavioural 64K x 16 memory. Directed
// copies push their hand-computed read addresses and {address, data} write
// pairs into expected queues; an independent negedge monitor pops and
// compares on every strobe. Cycle-accurate done/busy timing, reset state,
// final memory contents and checksum are checked by the stimulus thread.
// ---------------------------------------------------------------------------
module tb_mem_copy_engine;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              start;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [15:0]       len;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read_enable;
  logic              mem_write_enable;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;
  logic [15:0]       checksum;

  mem_copy_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .src_addr         (src_addr),
    .dst_addr         (dst_addr),
    .len              (len),
    .busy             (busy),
    .done             (done),
    .mem_address      (mem_address),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data),
    .checksum         (checksum)
  );

  // ---------------- memory model ----------------
  logic [15:0] mem [0:65535];
  logic        pl_we;
  logic [15:0] pl_addr;
  logic [15:0] pl_data;

  assign mem_read_data = mem[mem_address];

  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_address] <= mem_write_data;
    else if (pl_we)       mem[pl_addr]     <= pl_data;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_rd_q[$];
  logic [31:0] exp_wr_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_rw(input logic [15:0] rd, input logic [15:0] wa, input logic [15:0] wd);
    exp_rd_q.push_back(rd);
    exp_wr_q.push_back({wa, wd});
  endtask

  // Monitor: compares every memory strobe against the expected queues.
  always @(negedge clk) begin
    if (mem_read_enable && mem_write_enable)
      check("enables_exclusive", 32'd1, 32'd0);
    if (mem_read_enable) begin
      if (exp_rd_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_read: got addr 0x%0h expected no read", mem_address);
      end else begin
        check("read_addr", {16'h0, mem_address}, {16'h0, exp_rd_q.pop_front()});
      end
    end
    if (mem_write_enable) begin
      if (exp_wr_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                 mem_address, mem_write_data);
      end else begin
        check("write_addr_data", {mem_address, mem_write_data}, exp_wr_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  // Raises start for one edge (edge 0); afterwards inputs are scrambled to
  // prove they are only sampled on acceptance.
  task automatic do_start(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
    @(negedge clk);
    check("idle_busy_before_start", {31'h0, busy}, 32'd0);
    check("idle_done_before_start", {31'h0, done}, 32'd0);
    start = 1'b1; src_addr = s; dst_addr = d; len = l;
    @(posedge clk);
    #1;
    start = 1'b0; src_addr = 16'hBEEF; dst_addr = 16'h1234; len = 16'd7;
  endtask

  // Walks cycles 1..2l+1 after acceptance; optionally pulses a foreign start
  // in cycle ign (0 = none).
  task automatic watch(input string tag, input int l, input int ign);
    int done_cyc;
    int done_cnt;
    int busy_bad;
    int last;
    done_cyc = -1; done_cnt = 0; busy_bad = 0; last = 2 * l + 1;
    for (int n = 1; n <= last; n++) begin
      @(negedge clk);
      if (ign != 0 && n == ign) begin
        start = 1'b1; src_addr = 16'h0030; dst_addr = 16'h0300; len = 16'd2;
      end else if (ign != 0 && n == ign + 1) begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = n;
      end
      if (busy !== 1'b1) busy_bad++;
    end
    check({tag, "_done_cycle"}, done_cyc, last);
    check({tag, "_done_count"}, done_cnt, 32'd1);
    check({tag, "_busy_gaps"}, busy_bad, 32'd0);
    check({tag, "_rd_queue_drained"}, exp_rd_q.size(), 32'd0);
    check({tag, "_wr_queue_drained"}, exp_wr_q.size(), 32'd0);
  endtask

  task automatic check_sum(input string name, input logic [15:0] enabled_value);
`ifdef MEM_COPY_CHECKSUM_EN
    check(name, {16'h0, checksum}, {16'h0, enabled_value});
`else
    check(name, {16'h0, checksum}, 32'h0);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;

    preload(16'h0010, 16'h1111); preload(16'h0011, 16'h2222);
    preload(16'h0012, 16'h3333); preload(16'h0013, 16'h4444);
    preload(16'h0020, 16'h000A); preload(16'h0021, 16'h000B);
    preload(16'h0022, 16'h000C);
    preload(16'hFFFE, 16'hA001); preload(16'hFFFF, 16'hA002);
    preload(16'h0000, 16'hA003); preload(16'h0001, 16'hA004);
    preload(16'h0600, 16'h5A5A);
    preload(16'h0500, 16'hDEAD); preload(16'h0501, 16'hDEAD);

    // Reset state
    @(negedge clk);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_done", {31'h0, done}, 32'd0);
    check("rst_addr", {16'h0, mem_address}, 32'd0);
    check("rst_rd_en", {31'h0, mem_read_enable}, 32'd0);
    check("rst_wr_en", {31'h0, mem_write_enable}, 32'd0);
    check("rst_wdata", {16'h0, mem_write_data}, 32'd0);
    check("rst_checksum", {16'h0, checksum}, 32'd0);
    reset = 1'b0;

    // Basic copy 0x10 -> 0x100, len 4 (dst above src: top-down)
    push_rw(16'h0013, 16'h0103, 16'h4444);
    push_rw(16'h0012, 16'h0102, 16'h3333);
    push_rw(16'h0011, 16'h0101, 16'h2222);
    push_rw(16'h0010, 16'h0100, 16'h1111);
    do_start(16'h0010, 16'h0100, 16'd4);
    watch("basic", 4, 0);
    check_sum("basic_checksum", 16'hAAAA);
    check("basic_mem100", {16'h0, mem[16'h0100]}, 32'h1111);
    check("basic_mem101", {16'h0, mem[16'h0101]}, 32'h2222);
    check("basic_mem102", {16'h0, mem[16'h0102]}, 32'h3333);
    check("basic_mem103", {16'h0, mem[16'h0103]}, 32'h4444);

    // len = 0: done in cycle 1, no strobes, memory untouched
    do_start(16'h0010, 16'h0600, 16'd0);
    watch("len0", 0, 0);
    check_sum("len0_checksum", 16'h0000);
    check("len0_mem600", {16'h0, mem[16'h0600]}, 32'h5A5A);

    // Overlapping forward move 0x20 -> 0x21, len 3
    push_rw(16'h0022, 16'h0023, 16'h000C);
    push_rw(16'h0021, 16'h0022, 16'h000B);
    push_rw(16'h0020, 16'h0021, 16'h000A);
    do_start(16'h0020, 16'h0021, 16'd3);
    watch("overlap", 3, 0);
    check_sum("overlap_checksum", 16'h0021);
    check("overlap_mem21", {16'h0, mem[16'h0021]}, 32'h000A);
    check("overlap_mem22", {16'h0, mem[16'h0022]}, 32'h000B);
    check("overlap_mem23", {16'h0, mem[16'h0023]}, 32'h000C);

    // Source wraps through 0xFFFF -> 0x0000 (ascending)
    push_rw(16'hFFFE, 16'h0040, 16'hA001);
    push_rw(16'hFFFF, 16'h0041, 16'hA002);
    push_rw(16'h0000, 16'h0042, 16'hA003);
    push_rw(16'h0001, 16'h0043, 16'hA004);
    do_start(16'hFFFE, 16'h0040, 16'd4);
    watch("wrap", 4, 0);
    check_sum("wrap_checksum", 16'h800A);
    check("wrap_mem40", {16'h0, mem[16'h0040]}, 32'hA001);
    check("wrap_mem43", {16'h0, mem[16'h0043]}, 32'hA004);

    // Start in cycle 3 ignored; start in cycle after done accepted
    push_rw(16'h0013, 16'h0203, 16'h4444);
    push_rw(16'h0012, 16'h0202, 16'h3333);
    push_rw(16'h0011, 16'h0201, 16'h2222);
    push_rw(16'h0010, 16'h0200, 16'h1111);
    do_start(16'h0010, 16'h0200, 16'd4);
    watch("ignore", 4, 3);
    check_sum("ignore_checksum", 16'hAAAA);
    push_rw(16'h0100, 16'h0080, 16'h1111);
    push_rw(16'h0101, 16'h0081, 16'h2222);
    do_start(16'h0100, 16'h0080, 16'd2);
    watch("b2b", 2, 0);
    check_sum("b2b_checksum", 16'h3333);
    check("b2b_mem80", {16'h0, mem[16'h0080]}, 32'h1111);
    check("b2b_mem81", {16'h0, mem[16'h0081]}, 32'h2222);

    // Reset sampled at the end of the second word's WRITE (cycle 4)
    push_rw(16'h0013, 16'h0503, 16'h4444);
    push_rw(16'h0012, 16'h0502, 16'h3333);
    do_start(16'h0010, 16'h0500, 16'd4);
    for (int n = 1; n <= 4; n++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rstmid_busy", {31'h0, busy}, 32'd0);
    check("rstmid_done", {31'h0, done}, 32'd0);
    check("rstmid_rd_en", {31'h0, mem_read_enable}, 32'd0);
    check("rstmid_wr_en", {31'h0, mem_write_enable}, 32'd0);
    check("rstmid_checksum", {16'h0, checksum}, 32'd0);
    reset = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      check("rstmid_stays_idle", {31'h0, busy}, 32'd0);
    end
    check("rstmid_rd_queue_drained", exp_rd_q.size(), 32'd0);
    check("rstmid_wr_queue_drained", exp_wr_q.size(), 32'd0);
    check("rstmid_mem503", {16'h0, mem[16'h0503]}, 32'h4444);
    check("rstmid_mem502", {16'h0, mem[16'h0502]}, 32'h3333);
    check("rstmid_mem501", {16'h0, mem[16'h0501]}, 32'hDEAD);
    check("rstmid_mem500", {16'h0, mem[16'h0500]}, 32'hDEAD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected end of test");
    $fatal(1);
  end

endmodule
